// File: rtl/commit_packet_arbiter.sv
// Purpose: round-robin share of one commit writeback slot, holding the grant for a whole sop..eop packet.
// Latency: 1 cycle from beat acceptance to out_valid; sustains 1 beat/cycle.
// Backpressure: out_ready low with a full output stage holds the outputs and deasserts every req_ready.
module commit_packet_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW = 64,
    localparam int REQ_SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]       req_sop,
    input  logic [NUM_REQS-1:0]       req_eop,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [REQ_SEL_W-1:0]      out_sel,
    input  logic                      out_ready,
    output logic                      locked,
    output logic                      proto_err
);

    logic                 en;
    logic                 have_cand;
    logic                 acc;
    logic [REQ_SEL_W-1:0] cand;
    logic [REQ_SEL_W-1:0] cand_next;
    logic [REQ_SEL_W-1:0] rr_ptr;
    logic [REQ_SEL_W-1:0] lock_idx;
    logic [DATAW-1:0]     data_arr [NUM_REQS];

    // Unpack the flat payload bus so the selected beat is a plain array lookup.
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATAW +: DATAW];
    end

    // The output stage can take a new beat when empty or draining this cycle.
    assign en  = !out_valid || out_ready;
    assign acc = en && have_cand;

    // Pointer value after the winning requester, wrapping at NUM_REQS.
    assign cand_next = (int'(cand) == NUM_REQS - 1) ? '0 : cand + REQ_SEL_W'(1);

    // Pick the candidate: the locked owner only, otherwise first valid from rr_ptr upward.
    always_comb begin
        int                   idx;
        logic [REQ_SEL_W-1:0] try_idx;
        have_cand = 1'b0;
        cand      = '0;
        idx       = 0;
        try_idx   = '0;
        if (locked) begin
            cand      = lock_idx;
            have_cand = req_valid[lock_idx];
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQS) begin
                    idx = idx - NUM_REQS;
                end
                try_idx = REQ_SEL_W'(idx);
                if (!have_cand && req_valid[try_idx]) begin
                    have_cand = 1'b1;
                    cand      = try_idx;
                end
            end
        end
    end

    // Only the candidate sees ready, and only when the output stage can take the beat.
    always_comb begin
        req_ready = '0;
        if (acc) begin
            req_ready[cand] = 1'b1;
        end
    end

    // Output register, lock/pointer state and the protocol-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_sel   <= '0;
            locked    <= 1'b0;
            lock_idx  <= '0;
            rr_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            if (en) begin
                out_valid <= acc;
                if (acc) begin
                    out_data <= data_arr[cand];
                    out_sop  <= req_sop[cand];
                    out_eop  <= req_eop[cand];
                    out_sel  <= cand;
                end
            end
            if (acc) begin
                // A packet must open with sop exactly when no packet is in flight.
                proto_err <= locked ? req_sop[cand] : !req_sop[cand];
                if (req_eop[cand]) begin
                    locked <= 1'b0;
                    rr_ptr <= cand_next;
                end else begin
                    locked   <= 1'b1;
                    lock_idx <= cand;
                end
            end
        end
    end

endmodule
